trace_capture_unit: RTL and testbench

//  Parametrised on-chip trace buffer for the SingleCycleuProcessor datapath.

---
 rtl/trace_capture_unit_pkg.sv | 35 +++
 rtl/trace_capture_unit_if.sv | 51 +++++
 rtl/trace_capture_unit_ram.sv | 39 +++
 rtl/trace_capture_unit.sv | 172 +++++++++++++++++
 tb/tb_trace_capture_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/trace_capture_unit_pkg.sv
// rtl/trace_capture_unit_pkg.sv - shared types, trigger modes and sample layout for the trace capture unit
// Contents: capture FSM state encoding, TRIG_* mode codes, sample field
//   offsets and sample width as a function of DATA_W.
package trace_capture_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_IMM   = 2'b00;
  localparam logic [1:0] TRIG_PCSRC = 2'b01;
  localparam logic [1:0] TRIG_MATCH = 2'b10;
  localparam logic [1:0] TRIG_EXT   = 2'b11;

  // Sample layout, LSB first: RegWrite, MemWrite, PCSrc, ALUFlags[3:0],
  // ALUResult, Instr.
  localparam int REGWRITE_BIT = 0;
  localparam int MEMWRITE_BIT = 1;
  localparam int PCSRC_BIT    = 2;
  localparam int FLAGS_LSB    = 3;
  localparam int FLAGS_W      = 4;
  localparam int ALU_LSB      = FLAGS_LSB + FLAGS_W;

  function automatic int instr_lsb(input int data_w);
    return ALU_LSB + data_w;
  endfunction

  function automatic int sample_w(input int data_w);
    return 2 * data_w + ALU_LSB;
  endfunction

endpackage

// File: rtl/trace_capture_unit_if.sv
// rtl/trace_capture_unit_if.sv - processor sample, trigger control and readout bundle
// slave modport (trace unit): inputs arm, trig_mode, trig_match, trig_mask,
//   trig_in, post_count, Instr, ALUResult, ALUFlags, PCSrc, MemWrite,
//   RegWrite, rd_en, rd_addr; outputs rd_data, rd_valid, busy, done, count,
//   trig_idx.
// master modport (processor/debug side): the same signals, opposite direction.
interface trace_capture_unit_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
);
  import trace_capture_unit_pkg::*;

  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int SAMPLE_W = sample_w(DATA_W);

  logic                arm;
  logic [1:0]          trig_mode;
  logic [DATA_W-1:0]   trig_match;
  logic [DATA_W-1:0]   trig_mask;
  logic                trig_in;
  logic [ADDR_W-1:0]   post_count;
  logic [DATA_W-1:0]   Instr;
  logic [DATA_W-1:0]   ALUResult;
  logic [3:0]          ALUFlags;
  logic                PCSrc;
  logic                MemWrite;
  logic                RegWrite;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [SAMPLE_W-1:0] rd_data;
  logic                rd_valid;
  logic                busy;
  logic                done;
  logic [ADDR_W:0]     count;
  logic [ADDR_W-1:0]   trig_idx;

  modport slave (
    input  arm, trig_mode, trig_match, trig_mask, trig_in, post_count,
    input  Instr, ALUResult, ALUFlags, PCSrc, MemWrite, RegWrite,
    input  rd_en, rd_addr,
    output rd_data, rd_valid, busy, done, count, trig_idx
  );

  modport master (
    output arm, trig_mode, trig_match, trig_mask, trig_in, post_count,
    output Instr, ALUResult, ALUFlags, PCSrc, MemWrite, RegWrite,
    output rd_en, rd_addr,
    input  rd_data, rd_valid, busy, done, count, trig_idx
  );

endinterface

// File: rtl/trace_capture_unit_ram.sv
// rtl/trace_capture_unit_ram.sv - simple dual-port sample buffer with registered read
// Ports: clk, rst (async, active high, clears read register only);
//   wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request;
//   rd_data registered read data, holds when rd_en is low.
module trace_capture_unit_ram #(
  parameter int WIDTH = 71,
  parameter int DEPTH = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trace_capture_unit.sv
// rtl/trace_capture_unit.sv - circular trace buffer with programmable trigger and post-trigger window
// Ports: CLK; RST (async, active high); bus (trace_capture_unit_if.slave)
//   carrying arm/trigger setup, the per-cycle processor sample, the readout
//   request and the registered status/readout outputs.
module trace_capture_unit
  import trace_capture_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  trace_capture_unit_if.slave  bus
);

  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int SAMPLE_W = sample_w(DATA_W);
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]   post_eff_q, post_eff_d;
  logic [ADDR_W-1:0]   trig_idx_q, trig_idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_zero_q, rd_zero_d;

  logic                trig_hit;
  logic                wr_en;
  logic                rd_fire;
  logic [ADDR_W:0]     count_inc;
  logic [ADDR_W-1:0]   post_sel;
  logic [ADDR_W:0]     trig_calc;
  logic [ADDR_W-1:0]   rd_phys;
  logic [SAMPLE_W-1:0] wr_sample;
  logic [SAMPLE_W-1:0] ram_rdata;

  assign wr_sample = {bus.Instr, bus.ALUResult, bus.ALUFlags,
                      bus.PCSrc, bus.MemWrite, bus.RegWrite};

  always_comb begin
    trig_hit = 1'b0;
    case (bus.trig_mode)
      TRIG_IMM:   trig_hit = 1'b1;
      TRIG_PCSRC: trig_hit = bus.PCSrc;
      TRIG_MATCH: trig_hit = ((bus.Instr ^ bus.trig_match) & bus.trig_mask) == '0;
      TRIG_EXT:   trig_hit = bus.trig_in;
      default:    trig_hit = 1'b0;
    endcase
  end

  // Stored-sample count saturates once the buffer has wrapped.
  assign count_inc = (count_q == FULL) ? FULL : count_q + (ADDR_W + 1)'(1);

  // post_count is ADDR_W bits wide, so it can never exceed DEPTH-1: the
  // overwrite guard is inherent and the trigger sample always survives.
  assign post_sel  = (state_q == ST_PRE) ? bus.post_count : post_eff_q;
  assign trig_calc = count_inc - (ADDR_W + 1)'(1) - {1'b0, post_sel};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    post_eff_d = post_eff_q;
    trig_idx_d = trig_idx_q;
    wr_en      = 1'b0;
    // arm restarts from any state and overrides a same-cycle trigger or
    // completion; the arm cycle itself is not sampled.
    if (bus.arm) begin
      state_d = ST_PRE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_PRE: begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          count_d  = count_inc;
          if (trig_hit) begin
            post_eff_d = bus.post_count;
            post_cnt_d = bus.post_count;
            if (bus.post_count == '0) begin
              state_d    = ST_DONE;
              trig_idx_d = trig_calc[ADDR_W-1:0];
            end else begin
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
          count_d    = count_inc;
          post_cnt_d = post_cnt_q - ADDR_W'(1);
          if (post_cnt_q == ADDR_W'(1)) begin
            state_d    = ST_DONE;
            trig_idx_d = trig_calc[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d == ST_PRE) || (state_d == ST_POST);
    done_d = (state_d == ST_DONE);
  end

  // Readout: index 0 is the oldest stored sample. With a full buffer
  // count[ADDR_W-1:0] is 0, so the oldest sample sits at wr_ptr.
  assign rd_fire = bus.rd_en && (state_q == ST_DONE);
  assign rd_phys = wr_ptr_q - count_q[ADDR_W-1:0] + bus.rd_addr;

  always_comb begin
    rd_valid_d = rd_fire;
    rd_zero_d  = rd_zero_q;
    if (rd_fire) rd_zero_d = ({1'b0, bus.rd_addr} >= count_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      post_eff_q <= '0;
      trig_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      post_eff_q <= post_eff_d;
      trig_idx_q <= trig_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  trace_capture_unit_ram #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_sample),
    .rd_en   (rd_fire),
    .rd_addr (rd_phys),
    .rd_data (ram_rdata)
  );

  // Both mux inputs are registers, so rd_data has no path from the inputs.
  assign bus.rd_data  = rd_zero_q ? '0 : ram_rdata;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.trig_idx = trig_idx_q;

endmodule

// File: tb/tb_trace_capture_unit.sv
// tb/tb_trace_capture_unit.sv - scoreboard bench for trace_capture_unit
module tb_trace_capture_unit;
  import trace_capture_unit_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int SW     = 2 * DATA_W + 7;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  trace_capture_unit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  trace_capture_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [SW-1:0] exp_q [$];
  logic [SW-1:0] hist [$];
  logic [SW-1:0] last_rd = '0;
  logic [SW-1:0] mon_exp;

  // Monitor: every rd_valid beat must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (!RST && bus.rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got=%0h required=no_read", bus.rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.rd_data !== mon_exp) begin
          errors++;
          $display("FAIL rd_data got=%0h required=%0h", bus.rd_data, mon_exp);
        end
      end
    end
  end

  task automatic check_st(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic status(input string tag, input int b, input int d, input int c);
    check_st({tag, "_busy"},  int'(bus.busy),  b);
    check_st({tag, "_done"},  int'(bus.done),  d);
    check_st({tag, "_count"}, int'(bus.count), c);
  endtask

  task automatic sample(input logic [31:0] instr, input logic pc, input logic tin);
    bus.Instr     = instr;
    bus.ALUResult = instr ^ 32'h5A5A_0F0F;
    bus.ALUFlags  = instr[3:0];
    bus.PCSrc     = pc;
    bus.MemWrite  = instr[4];
    bus.RegWrite  = instr[5];
    bus.trig_in   = tin;
    hist.push_back({instr, instr ^ 32'h5A5A_0F0F, instr[3:0], pc, instr[4], instr[5]});
    @(negedge CLK);
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [5:0] post);
    bus.trig_mode  = mode;
    bus.post_count = post;
    bus.arm        = 1'b1;
    hist.delete();
    @(negedge CLK);
    bus.arm = 1'b0;
  endtask

  task automatic rd(input int a, input int cnt);
    logic [SW-1:0] e;
    e = (a >= cnt) ? '0 : hist[hist.size() - cnt + a];
    bus.rd_en   = 1'b1;
    bus.rd_addr = 6'(a);
    exp_q.push_back(e);
    last_rd = e;
    @(negedge CLK);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.arm = 0; bus.trig_mode = 0; bus.trig_match = 0; bus.trig_mask = 0;
    bus.trig_in = 0; bus.post_count = 0; bus.Instr = 0; bus.ALUResult = 0;
    bus.ALUFlags = 0; bus.PCSrc = 0; bus.MemWrite = 0; bus.RegWrite = 0;
    bus.rd_en = 0; bus.rd_addr = 0;

    repeat (2) @(negedge CLK);
    status("reset", 0, 0, 0);
    check_st("reset_trig_idx", int'(bus.trig_idx), 0);
    check_st("reset_rd_valid", int'(bus.rd_valid), 0);
    check_st("reset_rd_data_zero", int'(bus.rd_data == '0), 1);
    RST = 1'b0;
    @(negedge CLK);

    // Immediate trigger, 3 post samples.
    do_arm(TRIG_IMM, 6'd3);
    status("m00_pre", 1, 0, 0);
    for (int i = 0; i < 4; i++) sample(32'h1001_0000 + i, 1'b0, 1'b0);
    status("m00_done", 0, 1, 4);
    check_st("m00_trig_idx", int'(bus.trig_idx), 0);
    for (int a = 0; a <= 4; a++) rd(a, 4);

    // PCSrc trigger on the 10th PRE sample, 5 post samples.
    do_arm(TRIG_PCSRC, 6'd5);
    for (int i = 0; i < 15; i++) sample(32'h1002_0040 + i, (i == 9), 1'b0);
    status("m01_done", 0, 1, 15);
    check_st("m01_trig_idx", int'(bus.trig_idx), 9);
    rd(9, 15);
    rd(0, 15);
    rd(14, 15);

    // Instruction match after 200 wrapping PRE samples, 10 post samples.
    bus.trig_match = 32'h0A00_0000;
    bus.trig_mask  = 32'h0F00_0000;
    do_arm(TRIG_MATCH, 6'd10);
    for (int i = 0; i < 200; i++) begin
      if (i == 50) bus.rd_en = 1'b1;
      if (i == 51) begin
        check_st("pre_rd_valid", int'(bus.rd_valid), 0);
        checks++;
        if (bus.rd_data !== last_rd) begin
          errors++;
          $display("FAIL pre_rd_hold got=%0h required=%0h", bus.rd_data, last_rd);
        end
        bus.rd_en = 1'b0;
      end
      sample(32'h1003_0000 + i, 1'b0, 1'b0);
    end
    status("m10_pre", 1, 0, 64);
    sample(32'hFA00_1234, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) sample(32'h1003_1000 + i, 1'b0, 1'b0);
    status("m10_done", 0, 1, 64);
    check_st("m10_trig_idx", int'(bus.trig_idx), 53);
    rd(0, 64);
    rd(53, 64);
    rd(63, 64);

    // Largest post_count: whole buffer after the trigger sample.
    do_arm(TRIG_IMM, 6'h3F);
    for (int i = 0; i < 64; i++) sample(32'h1004_0000 + i, 1'b0, 1'b0);
    status("sat_done", 0, 1, 64);
    check_st("sat_trig_idx", int'(bus.trig_idx), 0);
    rd(0, 64);
    rd(63, 64);

    // External trigger, re-arm during POST, then async reset mid-PRE.
    do_arm(TRIG_EXT, 6'd20);
    for (int i = 0; i < 8; i++) sample(32'h1005_0000 + i, 1'b0, (i == 3));
    status("m11_post", 1, 0, 8);
    do_arm(TRIG_EXT, 6'd20);
    status("rearm_post", 1, 0, 0);
    for (int i = 0; i < 2; i++) sample(32'h1006_0000 + i, 1'b0, 1'b0);
    status("rearm_pre", 1, 0, 2);
    #2 RST = 1'b1;
    #1 status("async_rst", 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Recapture with post_count 0: trigger sample is the only one.
    do_arm(TRIG_IMM, 6'd0);
    sample(32'h1007_0000, 1'b1, 1'b0);
    status("post0_done", 0, 1, 1);
    check_st("post0_trig_idx", int'(bus.trig_idx), 0);
    rd(0, 1);
    rd(1, 1);

    repeat (3) @(negedge CLK);
    check_st("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
